// File: rtl/irq_pkg.sv
// Shared constants for the CTI-8 interrupt controller: register offsets,
// the "no interrupt" ID code and the reset values of the mask registers.
package irq_pkg;

  localparam logic [1:0] REG_PEND = 2'd0;
  localparam logic [1:0] REG_EN   = 2'd1;
  localparam logic [1:0] REG_EDGE = 2'd2;
  localparam logic [1:0] REG_ID   = 2'd3;

  localparam logic [7:0] ID_NONE  = 8'hFF;
  localparam logic [7:0] EN_RST   = 8'h00;
  localparam logic [7:0] EDGE_RST = 8'hFF;

endpackage

// File: rtl/irq_sync_edge.sv
// Single-bit 2-flop synchroniser followed by a delay flop for rising-edge detection.
module irq_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_en,
  input  logic d,
  output logic level,
  output logic rise
);

  logic sync_p0;
  logic sync_p1;
  logic dly_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      dly_p2  <= 1'b0;
    end else if (clk_en) begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
      dly_p2  <= sync_p1;
    end
  end

  assign level = sync_p1;
  assign rise  = sync_p1 & ~dly_p2;

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: pending/enable/edge registers, priority ID,
// registered level irq and fixed-width nmi pulse for the CTI-8 core.
module irq_controller
  import irq_pkg::*;
#(
  parameter logic [15:0] BASE      = 16'hFF00,
  parameter int          NSRC      = 8,
  parameter int          NMI_PULSE = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clk_en,
  input  logic [15:0]     addr,
  input  logic            wr,
  input  logic [7:0]      data_i,
  output logic [7:0]      data_o,
  output logic            data_oe,
  input  logic [NSRC-1:0] src,
  input  logic            nmi_src,
  output logic            irq,
  output logic            nmi
);

  localparam int         CNT_W    = $clog2(NMI_PULSE + 1);
  localparam logic [7:0] SRC_MASK = 8'((16'd1 << NSRC) - 16'd1);

  logic             sel;
  logic [1:0]       off;
  logic             wr_en;
  logic [7:0]       pend_q, en_q, edge_q;
  logic [7:0]       src_lvl, src_rise;
  logic [7:0]       set_v, clr_v, pend_d, act;
  logic [7:0]       id;
  logic             nmi_rise;
  logic             nmi_lvl_unused;
  logic [CNT_W-1:0] nmi_cnt;

  assign sel     = (addr[15:2] == BASE[15:2]);
  assign off     = addr[1:0];
  assign wr_en   = sel & wr & clk_en;
  assign data_oe = sel & ~wr;

  for (genvar g = 0; g < 8; g++) begin : g_src
    if (g < NSRC) begin : g_on
      irq_sync_edge u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_en (clk_en),
        .d      (src[g]),
        .level  (src_lvl[g]),
        .rise   (src_rise[g])
      );
    end else begin : g_off
      assign src_lvl[g]  = 1'b0;
      assign src_rise[g] = 1'b0;
    end
  end

  irq_sync_edge u_nmi_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .d      (nmi_src),
    .level  (nmi_lvl_unused),
    .rise   (nmi_rise)
  );

  // Set beats W1C; a held level source simply re-sets the bit it was asked to clear.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      set_v[i] = edge_q[i] ? src_rise[i] : src_lvl[i];
    end
    clr_v  = (wr_en && off == REG_PEND) ? data_i : 8'h00;
    pend_d = (set_v | (pend_q & ~clr_v)) & SRC_MASK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= 8'h00;
      en_q    <= EN_RST;
      edge_q  <= EDGE_RST & SRC_MASK;
      irq     <= 1'b0;
      nmi_cnt <= '0;
      nmi     <= 1'b0;
    end else if (clk_en) begin
      pend_q <= pend_d;
      if (wr_en && off == REG_EN)   en_q   <= data_i & SRC_MASK;
      if (wr_en && off == REG_EDGE) edge_q <= data_i & SRC_MASK;
      irq <= |(pend_q & en_q);
      if (nmi_rise)           nmi_cnt <= CNT_W'(NMI_PULSE);
      else if (nmi_cnt != '0) nmi_cnt <= nmi_cnt - CNT_W'(1);
      nmi <= (nmi_cnt != '0);
    end
  end

  // Descending scan so the lowest-numbered active source wins.
  always_comb begin
    act = pend_q & en_q;
    id  = ID_NONE;
    for (int i = 7; i >= 0; i--) begin
      if (act[i]) id = 8'(i);
    end
  end

  always_comb begin
    data_o = 8'h00;
    if (sel) begin
      case (off)
        REG_PEND: data_o = pend_q;
        REG_EN:   data_o = en_q;
        REG_EDGE: data_o = edge_q;
        default:  data_o = id;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: register table plus hand-built timing sequences.
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic        wr = 1'b0;
  logic [7:0]  data_i = 8'h00;
  logic [7:0]  data_o;
  logic        data_oe;
  logic [7:0]  src = 8'h00;
  logic        nmi_src = 1'b0;
  logic        irq;
  logic        nmi;

  int total = 0;
  int bad = 0;

  irq_controller #(.BASE(16'hFF00), .NSRC(8), .NMI_PULSE(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk_en  (clk_en),
    .addr    (addr),
    .wr      (wr),
    .data_i  (data_i),
    .data_o  (data_o),
    .data_oe (data_oe),
    .src     (src),
    .nmi_src (nmi_src),
    .irq     (irq),
    .nmi     (nmi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [15:0] addr;
    logic        wr;
    logic [7:0]  din;
    logic        chk;
    logic [7:0]  exp_do;
    logic        exp_oe;
  } vec_t;

  vec_t vt[15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic rd(input logic [1:0] off, input logic [7:0] exp, input string nm);
    addr = 16'hFF00 + 16'(off);
    wr   = 1'b0;
    #1;
    chk(nm, data_o, exp);
  endtask

  task automatic wr_reg(input logic [1:0] off, input logic [7:0] val);
    addr   = 16'hFF00 + 16'(off);
    wr     = 1'b1;
    data_i = val;
    tick();
    wr     = 1'b0;
    data_i = 8'h00;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic nmi_exp1[8];
    logic nmi_exp2[10];

    vt[0]  = '{1'b0, 16'hFF00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1};
    vt[1]  = '{1'b0, 16'hFF01, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1};
    vt[2]  = '{1'b0, 16'hFF02, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b1};
    vt[3]  = '{1'b0, 16'hFF03, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b1};
    vt[4]  = '{1'b0, 16'hFF04, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0};
    vt[5]  = '{1'b1, 16'hFF01, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b0};
    vt[6]  = '{1'b1, 16'hFF01, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b1};
    vt[7]  = '{1'b1, 16'hFF02, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b0};
    vt[8]  = '{1'b1, 16'hFF02, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b1};
    vt[9]  = '{1'b1, 16'hFF03, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
    vt[10] = '{1'b1, 16'hFF03, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b1};
    vt[11] = '{1'b1, 16'hFEFF, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0};
    vt[12] = '{1'b1, 16'hFF01, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
    vt[13] = '{1'b1, 16'hFF02, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0};
    vt[14] = '{1'b1, 16'hFF02, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b1};

    nmi_exp1 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    nmi_exp2 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    #3;
    chk("rst_irq", {7'b0, irq}, 8'h00);
    chk("rst_nmi", {7'b0, nmi}, 8'h00);

    for (int i = 0; i < 15; i++) begin
      rst_n  = vt[i].rst;
      addr   = vt[i].addr;
      wr     = vt[i].wr;
      data_i = vt[i].din;
      #1;
      if (vt[i].chk) chk($sformatf("vec%0d_do", i), data_o, vt[i].exp_do);
      chk($sformatf("vec%0d_oe", i), {7'b0, data_oe}, {7'b0, vt[i].exp_oe});
      tick();
      wr = 1'b0;
    end

    // Edge IRQ on source 2
    wr_reg(2'd1, 8'h04);
    src = 8'h04;
    tick();
    src = 8'h00;
    tick();
    chk("edge_irq_k1", {7'b0, irq}, 8'h00);
    tick();
    chk("edge_irq_k2", {7'b0, irq}, 8'h00);
    rd(2'd0, 8'h04, "edge_pend");
    tick();
    chk("edge_irq_k3", {7'b0, irq}, 8'h01);
    rd(2'd3, 8'h02, "edge_id");
    wr_reg(2'd0, 8'h04);
    chk("w1c_irq_same", {7'b0, irq}, 8'h01);
    rd(2'd0, 8'h00, "w1c_pend");
    tick();
    chk("w1c_irq_next", {7'b0, irq}, 8'h00);
    rd(2'd3, 8'hFF, "w1c_id");

    // Level mode and priority
    wr_reg(2'd2, 8'h00);
    wr_reg(2'd1, 8'h0A);
    src = 8'h0A;
    repeat (4) tick();
    rd(2'd3, 8'h01, "lvl_id01");
    chk("lvl_irq", {7'b0, irq}, 8'h01);
    wr_reg(2'd0, 8'h02);
    rd(2'd0, 8'h0A, "lvl_w1c_held");
    src = 8'h08;
    repeat (3) tick();
    wr_reg(2'd0, 8'h02);
    rd(2'd3, 8'h03, "lvl_id03");
    rd(2'd0, 8'h08, "lvl_pend08");
    src = 8'h00;
    repeat (3) tick();
    wr_reg(2'd2, 8'hFF);
    rd(2'd0, 8'h08, "edge_chg_keep");
    wr_reg(2'd1, 8'h00);
    wr_reg(2'd0, 8'hFF);
    rd(2'd0, 8'h00, "lvl_cleanup");

    // Masked pending
    src = 8'h20;
    repeat (3) tick();
    rd(2'd0, 8'h20, "mask_pend");
    chk("mask_irq0", {7'b0, irq}, 8'h00);
    tick();
    chk("mask_irq1", {7'b0, irq}, 8'h00);
    wr_reg(2'd1, 8'h20);
    tick();
    chk("mask_irq_en", {7'b0, irq}, 8'h01);
    src = 8'h00;
    wr_reg(2'd1, 8'h00);
    wr_reg(2'd0, 8'h20);
    tick();

    // Set/clear collision on bit 0
    wr_reg(2'd1, 8'h01);
    src = 8'h01;
    tick();
    src = 8'h00;
    tick();
    wr_reg(2'd0, 8'h01);
    rd(2'd0, 8'h01, "collide_pend");
    tick();

    // clk_en freeze with nmi in flight
    nmi_src = 1'b1;
    tick();
    nmi_src = 1'b0;
    repeat (3) tick();
    chk("frz_nmi_start", {7'b0, nmi}, 8'h01);
    chk("frz_irq_start", {7'b0, irq}, 8'h01);
    clk_en = 1'b0;
    addr   = 16'hFF00;
    data_i = 8'h01;
    wr     = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick();
      chk($sformatf("frz_nmi%0d", j), {7'b0, nmi}, 8'h01);
      chk($sformatf("frz_irq%0d", j), {7'b0, irq}, 8'h01);
    end
    wr = 1'b0;
    data_i = 8'h00;
    rd(2'd0, 8'h01, "frz_pend");
    clk_en = 1'b1;
    tick();
    chk("frz_nmi_r1", {7'b0, nmi}, 8'h01);
    tick();
    chk("frz_nmi_r2", {7'b0, nmi}, 8'h01);
    tick();
    chk("frz_nmi_r3", {7'b0, nmi}, 8'h00);
    wr_reg(2'd0, 8'h01);
    wr_reg(2'd1, 8'h00);
    repeat (2) tick();

    // NMI single pulse (source held high: one rise only)
    nmi_src = 1'b1;
    for (int j = 0; j < 8; j++) begin
      tick();
      chk($sformatf("nmi1_%0d", j), {7'b0, nmi}, {7'b0, nmi_exp1[j]});
    end
    nmi_src = 1'b0;
    repeat (3) tick();

    // NMI retrigger during the pulse
    nmi_src = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (j == 0) nmi_src = 1'b0;
      if (j == 1) nmi_src = 1'b1;
      if (j == 2) nmi_src = 1'b0;
      chk($sformatf("nmi2_%0d", j), {7'b0, nmi}, {7'b0, nmi_exp2[j]});
    end
    repeat (3) tick();

    // Asynchronous reset mid-pulse
    wr_reg(2'd1, 8'h20);
    nmi_src = 1'b1;
    repeat (4) tick();
    chk("rstmid_pre", {7'b0, nmi}, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_nmi", {7'b0, nmi}, 8'h00);
    chk("rstmid_irq", {7'b0, irq}, 8'h00);
    rd(2'd1, 8'h00, "rstmid_en");
    rd(2'd2, 8'hFF, "rstmid_edge");
    tick();
    rst_n = 1'b1;
    nmi_src = 1'b0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
